inst_fetcher: RTL and testbench
===============================

# inst_fetcher

Instruction fetch unit for the out-of-order RISC-V core, sitting between the memory controller, the branch predictor and the decoder. It holds the architectural fetch PC and a direct-mapped one-word-per-line instruction cache, and refills misses through the memory controller. On a hit it presents the PC and instruction word to the predictor and advances to the predicted next PC. It hands one instruction per cycle to the decoder and redirects on ROB rollback.

## Interface
- CACHE_IDX_W, 8: cache index width; 2^CACHE_IDX_W lines; index = pc[CACHE_IDX_W+1:2], tag = pc[31:CACHE_IDX_W+2].
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; all state frozen while low.
- mc_en  out  1  fetch request to memory controller, held until mc_done.
- mc_pc  out  32  word address of the request.
- mc_done  in  1  one-cycle pulse; mc_data valid.
- mc_data  in  32  fetched instruction word.
- pred_flag  out  1  high when pred_inst is a valid cache hit this cycle (combinational).
- pred_pc_out  out  32  current fetch PC to the predictor (combinational, equals pc).
- pred_inst  out  32  hit instruction word to the predictor (combinational).
- pred_pc  in  32  predicted next PC (combinational from predictor).
- pred_jump  in  1  predictor taken flag.
- stall  in  1  decoder/issue cannot accept; no instruction is issued.
- rob_set_pc_en  in  1  mispredict/rollback redirect.
- rob_set_pc  in  32  redirect target.
- inst_rdy  out  1  one-cycle pulse: inst/inst_pc/inst_pred_jump valid.
- inst  out  32  issued instruction.
- inst_pc  out  32  PC of issued instruction.
- inst_pred_jump  out  1  predictor decision recorded for the ROB.

## Operation
- State: registers pc, state ∈ {IDLE, WAIT_MEM}; arrays valid[], tag[], data[].
- hit = state==IDLE && valid[idx] && tag[idx]==pc tag. pred_flag = hit, pred_inst = data[idx], pred_pc_out = pc.
- Priority each cycle (rdy high, rst low): rollback > refill > issue > miss start.
- Rollback (rob_set_pc_en): pc <= rob_set_pc; inst_rdy <= 0; no issue. In IDLE: stay IDLE, no request started. In WAIT_MEM: mc_en stays high, wait continues; the returned word still fills the line (address is valid regardless of path).
- WAIT_MEM: mc_en held, mc_pc held. On mc_done: valid/tag/data[idx of mc_pc] written, mc_en <= 0, state <= IDLE. No issue this cycle.
- IDLE, hit, !stall, no rollback: inst_rdy <= 1, inst <= data[idx], inst_pc <= pc, inst_pred_jump <= pred_jump, pc <= pred_pc.
- IDLE, hit, stall: inst_rdy <= 0, pc held.
- IDLE, miss, no rollback: mc_en <= 1, mc_pc <= pc, state <= WAIT_MEM, inst_rdy <= 0 (stall ignored for refill).
- Otherwise inst_rdy <= 0.
- pc arithmetic 32-bit, wraps modulo 2^32; pc[1:0] never nonzero by construction.
- rdy low: no register or array changes; outputs hold; mc_done ignored (memory controller also frozen).
- Reset: pc=0, state=IDLE, all valid=0, mc_en=0, mc_pc=0, inst_rdy=0, inst=0, inst_pc=0, inst_pred_jump=0. Reset mid-WAIT_MEM abandons request; controller resets in same cycle.

## Timing
- Hit: pc presented cycle N, inst_rdy high in N+1, next pc in N+1; sustained 1 instr/cycle on consecutive hits.
- Predictor path combinational within cycle N (cache read → predictor → pc mux).
- Miss detected cycle N: mc_en high from N+1. mc_done at cycle M: line valid and state IDLE from M+1, hit in M+1, inst_rdy in M+2.
- Rollback at cycle R: pc = rob_set_pc from R+1; no inst_rdy in R+1 for the old path.
- inst_rdy never high two cycles for the same pc unless re-fetched after rollback.

## Test plan
- Cold miss: reset, mc_done 3 cycles after mc_en with mc_data=0x00000013 -> mc_pc=0, mc_en deasserts after done, inst_rdy with inst=0x13, inst_pc=0, next pc=4 (pred_pc=pc+4).
- Hot loop: preload 0x0..0xC, 0xC holds JAL -12 with pred_jump=1 -> inst_rdy every cycle, inst_pc sequence 0,4,8,C,0,… with inst_pred_jump=1 only at 0xC.
- Stall: hit at pc=8 with stall high 3 cycles -> inst_rdy low 3 cycles, pc stays 8, then one issue of pc=8.
- Rollback during WAIT_MEM: miss at 0x100, rob_set_pc_en=1 target 0x40 before mc_done -> mc_en stays high, line 0x100 filled, next fetch at 0x40, no issue of 0x100.
- Alias conflict: fill 0x0 then fetch 0x400 (same index, CACHE_IDX_W=8) -> miss, refill replaces; fetch of 0x0 again misses.
- rdy low 5 cycles mid-hit-stream and rst asserted in WAIT_MEM -> state frozen then resumes exactly; reset returns all outputs to 0 and all lines invalid.

Source files
------------

// File: rtl/inst_fetcher_if.sv
// Bus bundle between the instruction fetcher and its neighbours:
// memory controller (refill), branch predictor, ROB (redirect) and decoder (issue).
interface inst_fetcher_if;
   // memory controller refill channel
   logic        mc_en;
   logic [31:0] mc_pc;
   logic        mc_done;
   logic [31:0] mc_data;
   // branch predictor lookup
   logic        pred_flag;
   logic [31:0] pred_pc_out;
   logic [31:0] pred_inst;
   logic [31:0] pred_pc;
   logic        pred_jump;
   // decoder back-pressure and ROB redirect
   logic        stall;
   logic        rob_set_pc_en;
   logic [31:0] rob_set_pc;
   // issued instruction to the decoder
   logic        inst_rdy;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_pred_jump;

   modport master (
      output mc_en, mc_pc, pred_flag, pred_pc_out, pred_inst,
             inst_rdy, inst, inst_pc, inst_pred_jump,
      input  mc_done, mc_data, pred_pc, pred_jump, stall,
             rob_set_pc_en, rob_set_pc
   );

   modport slave (
      input  mc_en, mc_pc, pred_flag, pred_pc_out, pred_inst,
             inst_rdy, inst, inst_pc, inst_pred_jump,
      output mc_done, mc_data, pred_pc, pred_jump, stall,
             rob_set_pc_en, rob_set_pc
   );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch unit: fetch PC, direct-mapped one-word-per-line I-cache,
// miss refill through the memory controller, predictor lookup on hits and
// one-instruction-per-cycle issue to the decoder with ROB rollback redirect.
module inst_fetcher #(
   parameter int CACHE_IDX_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rdy,
   inst_fetcher_if.master bus
);
   localparam int LINES = 1 << CACHE_IDX_W;
   localparam int TAG_W = 32 - CACHE_IDX_W - 2;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } state_t;

   // architectural state
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        mc_en_q, mc_en_d;
   logic [31:0] mc_pc_q, mc_pc_d;
   logic        inst_rdy_q, inst_rdy_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_pred_jump_q, inst_pred_jump_d;

   // cache storage; only the valid bits are cleared by reset
   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   logic [CACHE_IDX_W-1:0] idx_s;
   logic [TAG_W-1:0]       tag_s;
   logic [CACHE_IDX_W-1:0] fill_idx_s;
   logic [TAG_W-1:0]       fill_tag_s;
   logic                   hit_s;
   logic                   fill_en_s;

   assign idx_s      = pc_q[CACHE_IDX_W+1:2];
   assign tag_s      = pc_q[31:CACHE_IDX_W+2];
   // the refill line is addressed by the held request, not by the current pc,
   // because a rollback may have moved pc while the request was in flight
   assign fill_idx_s = mc_pc_q[CACHE_IDX_W+1:2];
   assign fill_tag_s = mc_pc_q[31:CACHE_IDX_W+2];
   assign hit_s      = (state_q == ST_IDLE) && valid_q[idx_s] && (tag_q[idx_s] == tag_s);

   // predictor lookup is combinational within the fetch cycle
   assign bus.pred_flag   = hit_s;
   assign bus.pred_pc_out = pc_q;
   assign bus.pred_inst   = data_q[idx_s];

   assign bus.mc_en          = mc_en_q;
   assign bus.mc_pc          = mc_pc_q;
   assign bus.inst_rdy       = inst_rdy_q;
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign bus.inst_pred_jump = inst_pred_jump_q;

   // next-state logic: rollback > refill > issue > miss start
   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      mc_en_d          = mc_en_q;
      mc_pc_d          = mc_pc_q;
      inst_rdy_d       = 1'b0;
      inst_d           = inst_q;
      inst_pc_d        = inst_pc_q;
      inst_pred_jump_d = inst_pred_jump_q;
      fill_en_s        = 1'b0;

      // an outstanding refill completes even if a rollback arrives this cycle
      if (state_q == ST_WAIT_MEM && bus.mc_done) begin
         fill_en_s = 1'b1;
         mc_en_d   = 1'b0;
         state_d   = ST_IDLE;
      end else begin
         fill_en_s = 1'b0;
      end

      if (bus.rob_set_pc_en) begin
         pc_d = bus.rob_set_pc;
      end else if (state_q == ST_IDLE) begin
         if (hit_s) begin
            if (!bus.stall) begin
               inst_rdy_d       = 1'b1;
               inst_d           = data_q[idx_s];
               inst_pc_d        = pc_q;
               inst_pred_jump_d = bus.pred_jump;
               pc_d             = bus.pred_pc;
            end else begin
               pc_d = pc_q;
            end
         end else begin
            mc_en_d = 1'b1;
            mc_pc_d = pc_q;
            state_d = ST_WAIT_MEM;
         end
      end else begin
         pc_d = pc_q;
      end
   end

   // FSM and registered outputs; everything frozen while rdy is low
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         pc_q             <= 32'h0000_0000;
         mc_en_q          <= 1'b0;
         mc_pc_q          <= 32'h0000_0000;
         inst_rdy_q       <= 1'b0;
         inst_q           <= 32'h0000_0000;
         inst_pc_q        <= 32'h0000_0000;
         inst_pred_jump_q <= 1'b0;
         valid_q          <= {LINES{1'b0}};
      end else if (rdy) begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         mc_en_q          <= mc_en_d;
         mc_pc_q          <= mc_pc_d;
         inst_rdy_q       <= inst_rdy_d;
         inst_q           <= inst_d;
         inst_pc_q        <= inst_pc_d;
         inst_pred_jump_q <= inst_pred_jump_d;
         if (fill_en_s) begin
            valid_q[fill_idx_s] <= 1'b1;
         end
      end
   end

   // cache tag/data write on refill; contents are qualified by valid_q
   always_ff @(posedge clk) begin
      if (!rst && rdy && fill_en_s) begin
         tag_q[fill_idx_s]  <= fill_tag_s;
         data_q[fill_idx_s] <= bus.mc_data;
      end
   end
endmodule

// File: tb/tb_inst_fetcher.sv
// Directed self-checking bench for inst_fetcher: cold miss, hot loop, stall,
// rdy freeze, rollback during refill, alias replacement and reset mid-refill.
module tb_inst_fetcher;
   logic clk;
   logic rst;
   logic rdy;
   int   n_tests;
   int   n_fail;

   inst_fetcher_if bus ();

   inst_fetcher #(.CACHE_IDX_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   // predictor model: 0xC holds a JAL back to 0, everything else falls through
   assign bus.pred_jump = (bus.pred_pc_out == 32'h0000_000C);
   assign bus.pred_pc   = bus.pred_jump ? 32'h0000_0000 : bus.pred_pc_out + 32'd4;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // wait for a request, check its address, answer three cycles later
   task automatic refill(input logic [31:0] addr, input logic [31:0] word);
      int n;
      n = 0;
      while (!bus.mc_en && n < 10) begin
         tick();
         n++;
      end
      check_val("req_seen", {31'd0, bus.mc_en}, 32'd1);
      check_val("req_addr", bus.mc_pc, addr);
      tick();
      tick();
      check_val("req_held", {31'd0, bus.mc_en}, 32'd1);
      bus.mc_done = 1'b1;
      bus.mc_data = word;
      tick();
      bus.mc_done = 1'b0;
      bus.mc_data = 32'h0;
      check_val("req_drop", {31'd0, bus.mc_en}, 32'd0);
   endtask

   task automatic rollback(input logic [31:0] target);
      bus.rob_set_pc_en = 1'b1;
      bus.rob_set_pc    = target;
      tick();
      bus.rob_set_pc_en = 1'b0;
      bus.rob_set_pc    = 32'h0;
   endtask

   task automatic check_issue(input string tag, input logic [31:0] ipc, input logic [31:0] iword,
                              input logic jmp);
      check_val({tag, "_rdy"}, {31'd0, bus.inst_rdy}, 32'd1);
      check_val({tag, "_pc"}, bus.inst_pc, ipc);
      check_val({tag, "_inst"}, bus.inst, iword);
      check_val({tag, "_jmp"}, {31'd0, bus.inst_pred_jump}, {31'd0, jmp});
   endtask

   // watchdog so a stuck design still produces a verdict
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] prog [4];
      prog[0] = 32'h0000_0013;
      prog[1] = 32'h0010_0093;
      prog[2] = 32'h0020_0113;
      prog[3] = 32'hFF5F_F06F;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      rdy = 1'b1;
      bus.mc_done       = 1'b0;
      bus.mc_data       = 32'h0;
      bus.stall         = 1'b0;
      bus.rob_set_pc_en = 1'b0;
      bus.rob_set_pc    = 32'h0;
      tick();
      tick();

      // reset state
      check_val("rst_mc_en", {31'd0, bus.mc_en}, 32'd0);
      check_val("rst_inst_rdy", {31'd0, bus.inst_rdy}, 32'd0);
      check_val("rst_pc", bus.pred_pc_out, 32'h0);
      check_val("rst_flag", {31'd0, bus.pred_flag}, 32'd0);
      rst = 1'b0;

      // cold miss at 0, then fill the rest of the loop body
      refill(32'h0, prog[0]);
      check_val("cold_hit", {31'd0, bus.pred_flag}, 32'd1);
      tick();
      check_issue("cold", 32'h0, prog[0], 1'b0);
      check_val("cold_next_pc", bus.pred_pc_out, 32'h4);
      for (int i = 1; i < 4; i++) begin
         refill(32'(i * 4), prog[i]);
         tick();
         check_issue("fill", 32'(i * 4), prog[i], (i == 3));
      end
      check_val("loop_back", bus.pred_pc_out, 32'h0);

      // hot loop: one issue per cycle, 0,4,8,C,0,...
      for (int i = 0; i < 8; i++) begin
         tick();
         check_issue("loop", 32'((i % 4) * 4), prog[i % 4], ((i % 4) == 3));
      end

      // advance to pc=8, then stall three cycles
      tick();
      tick();
      check_val("pre_stall_pc", bus.pred_pc_out, 32'h8);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("stall_rdy", {31'd0, bus.inst_rdy}, 32'd0);
         check_val("stall_pc", bus.pred_pc_out, 32'h8);
      end
      bus.stall = 1'b0;
      tick();
      check_issue("post_stall", 32'h8, prog[2], 1'b0);

      // rdy low mid-stream: everything holds, then resumes exactly
      tick();
      check_issue("pre_freeze", 32'hC, prog[3], 1'b1);
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("frz_rdy", {31'd0, bus.inst_rdy}, 32'd1);
         check_val("frz_ipc", bus.inst_pc, 32'hC);
         check_val("frz_pc", bus.pred_pc_out, 32'h0);
      end
      rdy = 1'b1;
      tick();
      check_issue("resume", 32'h0, prog[0], 1'b0);

      // rollback wins over the pending hit at pc=4
      rollback(32'h100);
      check_val("rb_no_issue", {31'd0, bus.inst_rdy}, 32'd0);
      check_val("rb_pc", bus.pred_pc_out, 32'h100);
      tick();
      check_val("miss100_en", {31'd0, bus.mc_en}, 32'd1);
      check_val("miss100_pc", bus.mc_pc, 32'h100);
      // redirect while the refill is outstanding
      rollback(32'h40);
      check_val("rbw_en", {31'd0, bus.mc_en}, 32'd1);
      check_val("rbw_pc", bus.pred_pc_out, 32'h40);
      check_val("rbw_no_issue", {31'd0, bus.inst_rdy}, 32'd0);
      tick();
      bus.mc_done = 1'b1;
      bus.mc_data = 32'hAAAA_0001;
      tick();
      bus.mc_done = 1'b0;
      check_val("rbw_done", {31'd0, bus.mc_en}, 32'd0);
      check_val("rbw_no_issue2", {31'd0, bus.inst_rdy}, 32'd0);
      refill(32'h40, 32'hBBBB_0002);
      tick();
      check_issue("at40", 32'h40, 32'hBBBB_0002, 1'b0);
      // the abandoned line still got filled
      rollback(32'h100);
      check_val("fill100_flag", {31'd0, bus.pred_flag}, 32'd1);
      check_val("fill100_inst", bus.pred_inst, 32'hAAAA_0001);
      tick();
      check_issue("at100", 32'h100, 32'hAAAA_0001, 1'b0);

      // alias: 0x400 shares index 0 with 0x0
      rollback(32'h400);
      check_val("alias_miss", {31'd0, bus.pred_flag}, 32'd0);
      refill(32'h400, 32'hCCCC_0003);
      tick();
      check_issue("at400", 32'h400, 32'hCCCC_0003, 1'b0);
      rollback(32'h0);
      check_val("alias_evict", {31'd0, bus.pred_flag}, 32'd0);
      tick();
      check_val("alias_req", bus.mc_pc, 32'h0);

      // reset while waiting on memory
      check_val("wait_en", {31'd0, bus.mc_en}, 32'd1);
      rst = 1'b1;
      tick();
      check_val("rst2_mc_en", {31'd0, bus.mc_en}, 32'd0);
      check_val("rst2_mc_pc", bus.mc_pc, 32'h0);
      check_val("rst2_inst", bus.inst, 32'h0);
      check_val("rst2_ipc", bus.inst_pc, 32'h0);
      check_val("rst2_jmp", {31'd0, bus.inst_pred_jump}, 32'd0);
      check_val("rst2_pc", bus.pred_pc_out, 32'h0);
      rst = 1'b0;
      // line 8 was valid before reset; it must now miss
      rollback(32'h8);
      check_val("rst2_inval", {31'd0, bus.pred_flag}, 32'd0);
      check_val("rst2_no_req", {31'd0, bus.mc_en}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
